// File: rtl/tri_raster.sv
// rtl/tri_raster.sv - triangle rasteriser emitting covered integer points in row-major order
//
// Purpose: accepts three vertices on consecutive cycles, computes a bounding box
// and signed area, then walks the box one candidate per cycle and emits every
// point covered by the triangle (edges included when FILL_EDGE=1) over a
// po/out_ready handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   nt         in   new-triangle strobe, qualifies V0 on xi/yi (ignored while busy)
//   xi, yi     in   vertex coordinates, CW bits unsigned
//   out_ready  in   downstream accepts the current point
//   busy       out  triangle in progress
//   po         out  xo/yo valid
//   xo, yo     out  emitted point
//   done       out  one-cycle pulse at triangle completion
//   degen      out  last triangle had zero area, held until next nt is accepted
module tri_raster #(
    parameter int CW        = 3,
    parameter int FILL_EDGE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nt,
    input  logic [CW-1:0] xi,
    input  logic [CW-1:0] yi,
    input  logic          out_ready,
    output logic          busy,
    output logic          po,
    output logic [CW-1:0] xo,
    output logic [CW-1:0] yo,
    output logic          done,
    output logic          degen
);

    localparam int   AW = 2 * CW + 3;
    localparam logic FE = (FILL_EDGE != 0);

    typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, SETUP, SCAN, DRAIN, FIN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
    logic [CW-1:0] r_xmin, r_xmax, r_ymax;
    logic [CW-1:0] r_cx, r_cy;
    logic          r_neg;
    logic          r_po;
    logic [CW-1:0] r_xo, r_yo;
    logic          r_degen;
    logic          w_busy, w_done;

    function automatic logic signed [AW-1:0] ext(input logic [CW-1:0] v);
        return signed'({{(AW-CW){1'b0}}, v});
    endfunction

    // (b-a) x (p-a): same sign convention as the triangle area for every edge
    function automatic logic signed [AW-1:0] edge_fn(
        input logic [CW-1:0] ax, input logic [CW-1:0] ay,
        input logic [CW-1:0] bx, input logic [CW-1:0] by,
        input logic [CW-1:0] px, input logic [CW-1:0] py);
        return (ext(bx) - ext(ax)) * (ext(py) - ext(ay))
             - (ext(by) - ext(ay)) * (ext(px) - ext(ax));
    endfunction

    // True when e lies strictly on the other side from the area's sign
    function automatic logic opposite(input logic signed [AW-1:0] e, input logic neg);
        return neg ? (!e[AW-1] && (e != '0)) : e[AW-1];
    endfunction

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    logic signed [AW-1:0] w_area, w_e0, w_e1, w_e2;
    logic                 w_inside, w_stall, w_last;

    assign w_area = edge_fn(r_x0, r_y0, r_x1, r_y1, r_x2, r_y2);
    assign w_e0   = edge_fn(r_x0, r_y0, r_x1, r_y1, r_cx, r_cy);
    assign w_e1   = edge_fn(r_x1, r_y1, r_x2, r_y2, r_cx, r_cy);
    assign w_e2   = edge_fn(r_x2, r_y2, r_x0, r_y0, r_cx, r_cy);

    // Winding-independent: the area sign picks which side counts as inside
    assign w_inside = !(opposite(w_e0, r_neg) || opposite(w_e1, r_neg) || opposite(w_e2, r_neg))
                    && (FE || ((w_e0 != '0) && (w_e1 != '0) && (w_e2 != '0)));

    assign w_stall = r_po && !out_ready;
    assign w_last  = (r_cx == r_xmax) && (r_cy == r_ymax);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = (r_state != IDLE);
        w_done = 1'b0;
        case (r_state)
            IDLE:    if (nt) w_next = LOAD1;
            LOAD1:   w_next = LOAD2;
            LOAD2:   w_next = SETUP;
            SETUP:   w_next = (w_area == '0) ? FIN : SCAN;
            SCAN:    if (!w_stall && w_last) w_next = DRAIN;
            DRAIN:   if (!w_stall) w_next = FIN;
            FIN: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0; r_x2 <= '0; r_y2 <= '0;
            r_xmin <= '0; r_xmax <= '0; r_ymax <= '0;
            r_cx <= '0; r_cy <= '0; r_neg <= 1'b0;
            r_po <= 1'b0; r_xo <= '0; r_yo <= '0; r_degen <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (nt) begin
                    r_x0    <= xi;
                    r_y0    <= yi;
                    r_degen <= 1'b0;
                end
                LOAD1: begin
                    r_x1 <= xi;
                    r_y1 <= yi;
                end
                LOAD2: begin
                    r_x2 <= xi;
                    r_y2 <= yi;
                end
                SETUP: begin
                    r_xmin  <= min3(r_x0, r_x1, r_x2);
                    r_xmax  <= max3(r_x0, r_x1, r_x2);
                    r_ymax  <= max3(r_y0, r_y1, r_y2);
                    r_cx    <= min3(r_x0, r_x1, r_x2);
                    r_cy    <= min3(r_y0, r_y1, r_y2);
                    r_neg   <= w_area[AW-1];
                    r_degen <= (w_area == '0);
                end
                SCAN: if (!w_stall) begin
                    r_po <= w_inside;
                    r_xo <= r_cx;
                    r_yo <= r_cy;
                    // Row wrap only while rows remain, so r_cy never passes ymax
                    if (r_cx == r_xmax) begin
                        if (!w_last) begin
                            r_cx <= r_xmin;
                            r_cy <= r_cy + 1'b1;
                        end
                    end else begin
                        r_cx <= r_cx + 1'b1;
                    end
                end
                DRAIN: if (!w_stall) r_po <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy  = w_busy;
    assign done  = w_done;
    assign po    = r_po;
    assign xo    = r_xo;
    assign yo    = r_yo;
    assign degen = r_degen;

endmodule

// File: tb/tb_tri_raster.sv
// tb/tb_tri_raster.sv - directed self-checking bench for tri_raster
module tb_tri_raster;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] nt;
    logic [3:0] xi, yi;
    logic       out_ready;

    logic       busy_a, po_a, done_a, degen_a;
    logic [2:0] xo_a, yo_a;
    logic       busy_b, po_b, done_b, degen_b;
    logic [2:0] xo_b, yo_b;
    logic       busy_c, po_c, done_c, degen_c;
    logic [3:0] xo_c, yo_c;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qc[$];
    logic [7:0] exp_q[$];
    int         nb = 0;

    always #5 clk = ~clk;

    tri_raster #(.CW(3), .FILL_EDGE(1)) dut_a (
        .clk(clk), .reset(reset), .nt(nt[0]), .xi(xi[2:0]), .yi(yi[2:0]),
        .out_ready(out_ready), .busy(busy_a), .po(po_a), .xo(xo_a), .yo(yo_a),
        .done(done_a), .degen(degen_a));

    tri_raster #(.CW(3), .FILL_EDGE(0)) dut_b (
        .clk(clk), .reset(reset), .nt(nt[1]), .xi(xi[2:0]), .yi(yi[2:0]),
        .out_ready(out_ready), .busy(busy_b), .po(po_b), .xo(xo_b), .yo(yo_b),
        .done(done_b), .degen(degen_b));

    tri_raster #(.CW(4), .FILL_EDGE(1)) dut_c (
        .clk(clk), .reset(reset), .nt(nt[2]), .xi(xi), .yi(yi),
        .out_ready(out_ready), .busy(busy_c), .po(po_c), .xo(xo_c), .yo(yo_c),
        .done(done_c), .degen(degen_c));

    // Points are logged where the handshake completes; inputs only move at posedge+1
    always @(negedge clk) begin
        if (po_a && out_ready) qa.push_back({1'b0, xo_a, 1'b0, yo_a});
        if (po_b && out_ready) nb = nb + 1;
        if (po_c && out_ready) qc.push_back({xo_c, yo_c});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_busy(input int idx);
        return (idx == 0) ? busy_a : ((idx == 1) ? busy_b : busy_c);
    endfunction

    function automatic logic get_done(input int idx);
        return (idx == 0) ? done_a : ((idx == 1) ? done_b : done_c);
    endfunction

    function automatic logic get_degen(input int idx);
        return (idx == 0) ? degen_a : ((idx == 1) ? degen_b : degen_c);
    endfunction

    task automatic start_tri(input string tag, input int idx,
                             input logic [3:0] x0, input logic [3:0] y0,
                             input logic [3:0] x1, input logic [3:0] y1,
                             input logic [3:0] x2, input logic [3:0] y2);
        tick();
        nt[idx] = 1'b1; xi = x0; yi = y0;
        #1;
        chk({tag, "_busy_pre"}, get_busy(idx), 1'b0);
        tick();
        chk({tag, "_busy_post"}, get_busy(idx), 1'b1);
        nt[idx] = 1'b0; xi = x1; yi = y1;
        tick();
        xi = x2; yi = y2;
    endtask

    task automatic wait_done(input string tag, input int idx, input int budget, output int cycles);
        logic got;
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            cycles++;
            got = get_done(idx);
        end
        chk({tag, "_done"}, got, 1'b1);
    endtask

    task automatic chk_pts(input string tag, input int idx);
        int n;
        n = (idx == 0) ? qa.size() : qc.size();
        chk({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n) chk($sformatf("%s_pt%0d", tag, i), (idx == 0) ? qa[i] : qc[i], exp_q[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1; nt = '0; xi = '0; yi = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_po", po_a, 1'b0);
        chk("rst_xoyo", {xo_a, yo_a}, 6'd0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_degen", degen_a, 1'b0);
        reset = 1'b0;

        // Basic right triangle
        qa.delete();
        exp_q = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11, 8'h02};
        start_tri("t033", 0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd2);
        wait_done("t033", 0, 60, cyc);
        chk("t033_degen", degen_a, 1'b0);
        chk_pts("t033", 0);
        tick();
        chk("t033_done_pulse", done_a, 1'b0);
        chk("t033_busy_after", busy_a, 1'b0);

        // Opposite winding
        qa.delete();
        start_tri("t034", 0, 4'd0, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0);
        wait_done("t034", 0, 60, cyc);
        chk("t034_degen", degen_a, 1'b0);
        chk_pts("t034", 0);

        // Interior-only: this triangle has no strictly interior lattice point
        nb = 0;
        start_tri("t034b", 1, 4'd0, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0);
        wait_done("t034b", 1, 60, cyc);
        chk("t034b_degen", degen_b, 1'b0);
        chk("t034b_npts", nb, 0);

        // Collinear vertices
        qa.delete();
        start_tri("t035", 0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2);
        wait_done("t035", 0, 10, cyc);
        chk("t035_latency_ok", (cyc + 2 <= 5), 1'b1);
        chk("t035_degen", degen_a, 1'b1);
        chk("t035_npts", qa.size(), 0);
        tick(); tick(); tick();
        chk("t035_degen_held", get_degen(0), 1'b1);
        chk("t035_busy", busy_a, 1'b0);

        // Box at the top of the coordinate range; also degen clears on nt
        qa.delete();
        exp_q = '{8'h75, 8'h66, 8'h76, 8'h57, 8'h67, 8'h77};
        start_tri("tmax", 0, 4'd7, 4'd7, 4'd5, 4'd7, 4'd7, 4'd5);
        chk("tmax_degen_clr", degen_a, 1'b0);
        wait_done("tmax", 0, 60, cyc);
        chk_pts("tmax", 0);

        // Backpressure on the second point
        qa.delete();
        exp_q = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11, 8'h02};
        start_tri("t036", 0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd2);
        cyc = 0;
        while (!(po_a && xo_a == 3'd1 && yo_a == 3'd0) && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("t036_found", {po_a, xo_a, yo_a}, {1'b1, 3'd1, 3'd0});
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t036_hold%0d", k), {po_a, xo_a, yo_a}, {1'b1, 3'd1, 3'd0});
        end
        out_ready = 1'b1;
        wait_done("t036", 0, 60, cyc);
        chk_pts("t036", 0);

        // nt during SCAN is neither honoured nor queued
        qa.delete();
        start_tri("t037n", 0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd2);
        tick(); tick(); tick(); tick();
        nt[0] = 1'b1; xi = 4'd3; yi = 4'd3;
        tick();
        nt[0] = 1'b0;
        wait_done("t037n", 0, 60, cyc);
        chk_pts("t037n", 0);
        tick(); tick(); tick();
        chk("t037n_not_queued", busy_a, 1'b0);

        // Reset mid-SCAN, then a clean render
        start_tri("t037r", 0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd2);
        cyc = 0;
        while (!po_a && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("t037r_inscan", po_a, 1'b1);
        reset = 1'b1;
        tick();
        chk("t037r_busy", busy_a, 1'b0);
        chk("t037r_po", po_a, 1'b0);
        chk("t037r_xoyo", {xo_a, yo_a}, 6'd0);
        reset = 1'b0;
        qa.delete();
        start_tri("t037b", 0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd2);
        wait_done("t037b", 0, 60, cyc);
        chk_pts("t037b", 0);

        // Wider coordinates, mixed-slope triangle
        qc.delete();
        exp_q = '{8'h10, 8'h11, 8'h21, 8'h12, 8'h22, 8'h32, 8'h42, 8'h13, 8'h23, 8'h14};
        start_tri("t038", 2, 4'd1, 4'd0, 4'd1, 4'd4, 4'd4, 4'd2);
        wait_done("t038", 2, 80, cyc);
        chk("t038_degen", degen_c, 1'b0);
        chk_pts("t038", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_raster.md
TRI_RASTER -- requirements
Module: tri_raster

Interface
REQ-001 SHALL have parameter CW, default 3, meaning the coordinate width in bits for xi, yi, xo and yo (range 3..8).
REQ-002 SHALL have parameter FILL_EDGE, default 1: 1 emits points on triangle edges, 0 emits strictly interior points only.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge triggered.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port nt  input  1  new-triangle strobe, qualifies the first vertex.
REQ-006 SHALL have port xi  input  CW  vertex x coordinate, unsigned.
REQ-007 SHALL have port yi  input  CW  vertex y coordinate, unsigned.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the current point.
REQ-009 SHALL have port busy  output  1  triangle in progress; nt is ignored while high.
REQ-010 SHALL have port po  output  1  xo/yo valid.
REQ-011 SHALL have port xo  output  CW  emitted point x.
REQ-012 SHALL have port yo  output  CW  emitted point y.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a triangle completes.
REQ-014 SHALL have port degen  output  1  the last triangle had zero area; held until the next nt is accepted.

Function
REQ-015 SHALL implement states IDLE, LOAD1, LOAD2, SETUP, SCAN, DRAIN and FIN.
REQ-016 In IDLE, nt=1 at a rising edge SHALL capture xi/yi as V0 and go to LOAD1; nt=0 stays in IDLE.
REQ-017 LOAD1 and LOAD2 SHALL capture V1 and V2 unconditionally on the next two edges; nt is don't-care there.
REQ-018 busy SHALL be 1 in every state except IDLE, so it rises the cycle after nt is accepted.
REQ-019 SETUP (1 cycle) SHALL compute the bounding box xmin/xmax/ymin/ymax and signed area A = (x1-x0)(y2-y0) - (y1-y0)(x2-x0), at least 2*CW+3 bits wide.
REQ-020 If A=0, SETUP SHALL go to FIN with degen=1 and emit no points.
REQ-021 SCAN SHALL visit one candidate per cycle in row-major order: y from ymin to ymax, x from xmin to xmax within each row.
REQ-022 For each candidate, edge values Ei SHALL be computed for edges V0V1, V1V2 and V2V0 with the same sign convention as A.
REQ-023 A candidate is inside when no Ei has the opposite sign of A; with FILL_EDGE=0, every Ei must also be nonzero.
REQ-024 The result SHALL be independent of vertex order or winding.
REQ-025 An inside candidate SHALL drive registered po=1 with xo/yo on the cycle after evaluation; otherwise po=0.
REQ-026 While po=1 and out_ready=0, po/xo/yo SHALL hold and the scan SHALL stall; a point is consumed only on po&out_ready.
REQ-027 After the last candidate, DRAIN SHALL wait until any pending point is accepted, then go to FIN.
REQ-028 FIN SHALL last 1 cycle with done=1, then return to IDLE; busy SHALL be 0 on the following cycle.
REQ-029 nt asserted while busy=1 SHALL have no effect, and SHALL NOT be queued.
REQ-030 A bounding box of a single row or column SHALL be handled without wrap; coordinates SHALL never overflow CW bits.

Reset
REQ-031 reset=1 SHALL force IDLE and set busy=0, po=0, xo=0, yo=0, done=0, degen=0 at the next edge, including mid-SCAN or mid-LOAD.
REQ-032 reset SHALL take priority over nt on the same edge; points pending at reset SHALL be discarded.

Verification
REQ-033 CW=3, FILL_EDGE=1, V=(0,0),(2,0),(0,2), out_ready=1 -> po for exactly (0,0),(1,0),(2,0),(0,1),(1,1),(0,2) in that order, then done pulse, degen=0.
REQ-034 Same vertices reordered (0,2),(2,0),(0,0) -> identical 6-point sequence; with FILL_EDGE=0 -> zero po, done pulse, degen=0.
REQ-035 V=(0,0),(1,1),(2,2) -> zero po, done within 5 cycles of nt, degen=1.
REQ-036 Test 033 with out_ready low for 3 cycles on the 2nd point -> (1,0) held stable 4 cycles, no point lost or duplicated.
REQ-037 nt pulsed during SCAN -> ignored; reset asserted mid-SCAN -> busy=0 and po=0 next cycle; a new triangle then renders correctly.
REQ-038 CW=4, V=(1,0),(1,4),(4,2), FILL_EDGE=1 -> point set matches a software edge-function model, in row-major order.
